signal_cfg_update_ctrl: RTL and testbench
=========================================

Name: signal_cfg_update_ctrl

Overview:
Atomic update controller for the 832-bit per-channel signal configuration bus (ramp frequency, offset, calibration, four DDS components).
- Host writes 32-bit words into a shadow buffer.
- A commit copies the whole shadow to the active cfg_data bus in a single cycle, either immediately or after a programmable number of signal-period sync pulses.
- Downstream generators therefore never see a half-updated frequency/phase/amplitude set.
- Sits between the host register interface and the signal configuration slicer.

Parameters:
CFG_WIDTH, 832, width of the active/shadow configuration bus
WORD_WIDTH, 32, host write word width; CFG_WIDTH must be an integer multiple
NUM_WORDS, 26, CFG_WIDTH/WORD_WIDTH
ADDR_WIDTH, 5, word address width, ceil(log2(NUM_WORDS))
WAIT_WIDTH, 8, width of the sync-pulse wait count

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
wr_valid  input  1  host word write request
wr_ready  output  1  shadow accepts writes
wr_addr  input  ADDR_WIDTH  word index; word i maps to bits [32i+31:32i]
wr_data  input  WORD_WIDTH  write data
commit_req  input  1  single-cycle commit request
commit_wait  input  WAIT_WIDTH  sync pulses to wait; 0 = immediate
sync_pulse  input  1  single-cycle period-boundary strobe from the ramp generator
abort  input  1  cancel an armed commit
err_clr  input  1  clear sticky error flags
cfg_data  output  CFG_WIDTH  active configuration
cfg_update  output  1  one-cycle strobe in the cycle cfg_data first shows new contents
armed  output  1  commit pending, waiting for sync
addr_err  output  1  sticky: write to address >= NUM_WORDS
commit_err  output  1  sticky: commit_req received while not IDLE
commit_count  output  16  number of completed commits, wraps modulo 2^16

Behaviour:
Clock and reset:
- One clock (clk); reset is synchronous and active-high.
- Reset clears shadow, cfg_data, wait counter, commit_count, addr_err, commit_err and cfg_update to 0, and sets state to IDLE.
- Reset asserted mid-ARMED or mid-APPLY discards the pending commit; no cfg_update is issued.

States:
- IDLE: wr_ready=1, armed=0.
- ARMED: wr_ready=0, armed=1.
- APPLY: wr_ready=0, armed=0; lasts exactly 1 cycle.

Writes:
- A write is accepted on any edge where wr_valid=1 and wr_ready=1.
- The shadow word updates at that edge.
- wr_addr >= NUM_WORDS: data dropped, addr_err set.
- cfg_data never changes on a write.

Commit:
- commit_req in IDLE with commit_wait=0: next state APPLY.
- commit_req in IDLE with commit_wait=N>0: next state ARMED, wait counter loaded with N.
- A write and commit_req in the same IDLE cycle: the write is included in the commit.
- APPLY: at the following edge, cfg_data <= shadow, cfg_update=1 for exactly one cycle, commit_count increments, state returns to IDLE.
- Immediate-commit latency: cfg_data shows the new value 2 cycles after commit_req is sampled.

ARMED:
- Each sync_pulse decrements the counter.
- sync_pulse while the counter equals 1: next state APPLY, so cfg_data changes 2 cycles after the N-th sync_pulse.
- A sync_pulse coincident with commit_req (IDLE cycle) is not counted.
- abort in ARMED: return to IDLE with no update and no count change.
- abort and the final sync_pulse in the same cycle: abort wins.
- abort in IDLE or APPLY is ignored.

Errors:
- commit_req in ARMED or APPLY is ignored and sets commit_err.
- err_clr clears both sticky flags.
- An error event coincident with err_clr leaves the flag set.

Other rules:
- cfg_update is 0 in every cycle other than the one following APPLY.
- commit_count wraps from 0xFFFF to 0x0000.

Test Plan:
- Reset, then write words 0..25 with value 0x1000+i, then commit_req with commit_wait=0 -> cfg_data unchanged until commit_req+2 cycles; then each word i = 0x1000+i, cfg_update high for exactly 1 cycle, commit_count=1.
- Write word 2 = 0xDEADBEEF, commit_req with commit_wait=3, sync_pulse every 10 cycles -> armed=1, wr_ready=0, cfg_data[95:64] holds the old value until 2 cycles after the 3rd sync_pulse, then 0xDEADBEEF.
- While ARMED, assert wr_valid to word 5 -> not accepted (wr_ready=0); shadow and applied word 5 unchanged. A second commit_req -> commit_err=1, no extra update.
- ARMED with commit_wait=2; abort together with the 2nd sync_pulse -> IDLE, no cfg_update, commit_count unchanged. Also cover reset asserted mid-ARMED -> all outputs zero, no cfg_update.
- Write to wr_addr=26 and 31 -> addr_err=1, cfg_data and shadow unchanged after a commit. err_clr -> addr_err=0.
- Preload commit_count to 0xFFFF via 65535 immediate commits (or force) then one more commit -> commit_count=0x0000.

Source files
------------

// File: rtl/signal_cfg_update_ctrl_if.sv
// Purpose: host-side bundle for the signal configuration update controller.
// Signals: word write handshake (wr_valid/wr_ready/wr_addr/wr_data), commit
// control (commit_req/commit_wait/sync_pulse/abort/err_clr) and status/result
// (cfg_data/cfg_update/armed/addr_err/commit_err/commit_count).
// Modports: master = host/bench side, slave = controller side.
interface signal_cfg_update_ctrl_if #(
    parameter int unsigned CFG_WIDTH  = 832,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned WAIT_WIDTH = 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  commit_req;
    logic [WAIT_WIDTH-1:0] commit_wait;
    logic                  sync_pulse;
    logic                  abort;
    logic                  err_clr;
    logic [CFG_WIDTH-1:0]  cfg_data;
    logic                  cfg_update;
    logic                  armed;
    logic                  addr_err;
    logic                  commit_err;
    logic [15:0]           commit_count;

    modport master (
        output wr_valid, wr_addr, wr_data, commit_req, commit_wait,
               sync_pulse, abort, err_clr,
        input  wr_ready, cfg_data, cfg_update, armed, addr_err,
               commit_err, commit_count
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit_req, commit_wait,
               sync_pulse, abort, err_clr,
        output wr_ready, cfg_data, cfg_update, armed, addr_err,
               commit_err, commit_count
    );
endinterface

// File: rtl/signal_cfg_update_ctrl.sv
// Purpose: atomic update controller for the per-channel signal configuration
// bus. Host words land in a shadow buffer; a commit copies the whole shadow to
// cfg_data in one cycle, immediately or after a number of sync pulses.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - slave side of signal_cfg_update_ctrl_if (writes, commit control,
//           active configuration and status)
module signal_cfg_update_ctrl #(
    parameter int unsigned CFG_WIDTH  = 832,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned WAIT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    signal_cfg_update_ctrl_if.slave  bus
);
    localparam int unsigned NUM_WORDS = CFG_WIDTH / WORD_WIDTH;
    localparam int unsigned CNT_WIDTH = 16;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_APPLY = 2'd2
    } state_e;

    state_e                                 state_q, state_d;
    logic [WAIT_WIDTH-1:0]                  wait_cnt_q, wait_cnt_d;
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]   shadow_q, shadow_d;
    logic [CFG_WIDTH-1:0]                   cfg_data_q, cfg_data_d;
    logic                                   cfg_update_q, cfg_update_d;
    logic                                   wr_ready_q, wr_ready_d;
    logic                                   armed_q, armed_d;
    logic                                   addr_err_q, addr_err_d;
    logic                                   commit_err_q, commit_err_d;
    logic [CNT_WIDTH-1:0]                   commit_count_q, commit_count_d;

    logic wr_fire;
    logic addr_ok;

    // wr_ready_q mirrors "state is IDLE", so it doubles as the write enable
    assign wr_fire = bus.wr_valid & wr_ready_q;
    assign addr_ok = (bus.wr_addr <= LAST_ADDR);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            wait_cnt_q     <= '0;
            shadow_q       <= '0;
            cfg_data_q     <= '0;
            cfg_update_q   <= 1'b0;
            wr_ready_q     <= 1'b1;
            armed_q        <= 1'b0;
            addr_err_q     <= 1'b0;
            commit_err_q   <= 1'b0;
            commit_count_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            shadow_q       <= shadow_d;
            cfg_data_q     <= cfg_data_d;
            cfg_update_q   <= cfg_update_d;
            wr_ready_q     <= wr_ready_d;
            armed_q        <= armed_d;
            addr_err_q     <= addr_err_d;
            commit_err_q   <= commit_err_d;
            commit_count_q <= commit_count_d;
        end
    end

    // Next-state and sync-pulse wait counter
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // A sync pulse in the commit cycle is deliberately not counted
                if (bus.commit_req) begin
                    if (bus.commit_wait == '0) begin
                        state_d = ST_APPLY;
                    end else begin
                        state_d    = ST_ARMED;
                        wait_cnt_d = bus.commit_wait;
                    end
                end
            end
            ST_ARMED: begin
                // abort has priority over the final sync pulse
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.sync_pulse) begin
                    wait_cnt_d = wait_cnt_q - WAIT_WIDTH'(1);
                    if (wait_cnt_q == WAIT_WIDTH'(1)) begin
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, shadow buffer and sticky flags
    always_comb begin
        wr_ready_d     = (state_d == ST_IDLE);
        armed_d        = (state_d == ST_ARMED);
        cfg_update_d   = 1'b0;
        cfg_data_d     = cfg_data_q;
        commit_count_d = commit_count_q;
        shadow_d       = shadow_q;
        addr_err_d     = addr_err_q & ~bus.err_clr;
        commit_err_d   = commit_err_q & ~bus.err_clr;

        if (wr_fire) begin
            if (addr_ok) begin
                shadow_d[bus.wr_addr] = bus.wr_data;
            end else begin
                addr_err_d = 1'b1;
            end
        end

        if (bus.commit_req && (state_q != ST_IDLE)) begin
            commit_err_d = 1'b1;
        end

        if (state_q == ST_APPLY) begin
            cfg_data_d     = shadow_q;
            cfg_update_d   = 1'b1;
            commit_count_d = commit_count_q + CNT_WIDTH'(1);
        end
    end

    assign bus.wr_ready     = wr_ready_q;
    assign bus.armed        = armed_q;
    assign bus.cfg_data     = cfg_data_q;
    assign bus.cfg_update   = cfg_update_q;
    assign bus.addr_err     = addr_err_q;
    assign bus.commit_err   = commit_err_q;
    assign bus.commit_count = commit_count_q;
endmodule

// File: tb/tb_signal_cfg_update_ctrl.sv
module tb_signal_cfg_update_ctrl;
    localparam int unsigned CFG_WIDTH  = 832;
    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned WAIT_WIDTH = 8;
    localparam int unsigned NUM_WORDS  = 26;

    typedef struct {
        logic [CFG_WIDTH-1:0] cfg;
        logic [15:0]          cnt;
    } exp_t;

    logic clk;
    logic reset;

    signal_cfg_update_ctrl_if #(
        .CFG_WIDTH(CFG_WIDTH), .WORD_WIDTH(WORD_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .WAIT_WIDTH(WAIT_WIDTH)
    ) bus ();

    signal_cfg_update_ctrl #(
        .CFG_WIDTH(CFG_WIDTH), .WORD_WIDTH(WORD_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .WAIT_WIDTH(WAIT_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [WORD_WIDTH-1:0] shadow_m  [NUM_WORDS];
    logic [WORD_WIDTH-1:0] applied_m [NUM_WORDS];
    logic [15:0]           count_m;
    exp_t                  exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid    = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.commit_req  = 1'b0;
        bus.commit_wait = '0;
        bus.sync_pulse  = 1'b0;
        bus.abort       = 1'b0;
        bus.err_clr     = 1'b0;
    endtask

    function automatic logic [CFG_WIDTH-1:0] pack_words(input logic [WORD_WIDTH-1:0] w [NUM_WORDS]);
        logic [CFG_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NUM_WORDS); i++) v[32*i +: 32] = w[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NUM_WORDS); i++) begin
            shadow_m[i]  = '0;
            applied_m[i] = '0;
        end
        count_m = '0;
    endtask

    // Write in IDLE; model tracks only in-range addresses
    task automatic write_word(input int a, input logic [31:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = ADDR_WIDTH'(a);
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
        if (a < int'(NUM_WORDS)) shadow_m[a] = d;
    endtask

    // Expected commit result is queued when the commit request is driven
    task automatic push_expected();
        exp_t e;
        count_m = count_m + 16'd1;
        e.cfg = pack_words(shadow_m);
        e.cnt = count_m;
        exp_q.push_back(e);
        applied_m = shadow_m;
    endtask

    task automatic commit_now();
        push_expected();
        bus.commit_req  = 1'b1;
        bus.commit_wait = '0;
        tick();
        bus.commit_req  = 1'b0;
    endtask

    // Scoreboard: every cfg_update must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && bus.cfg_update) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_update cnt=%h expected no update", bus.commit_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.cfg_data !== e.cfg || bus.commit_count !== e.cnt) begin
                    n_bad++;
                    $display("FAIL sb_cfg got %h exp %h", bus.cfg_data, e.cfg);
                    $display("FAIL sb_count got %h exp %h", bus.commit_count, e.cnt);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick(); tick();
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if (bus.cfg_data !== '0 || bus.cfg_update !== 1'b0 || bus.armed !== 1'b0 ||
            bus.wr_ready !== 1'b1 || bus.commit_count !== 16'h0 ||
            bus.addr_err !== 1'b0 || bus.commit_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state rdy=%b arm=%b upd=%b cnt=%h ae=%b ce=%b exp rdy=1 others 0",
                     bus.wr_ready, bus.armed, bus.cfg_update, bus.commit_count,
                     bus.addr_err, bus.commit_err);
        end
    endtask

    task automatic test_immediate();
        for (int i = 0; i < int'(NUM_WORDS); i++) write_word(i, 32'h1000 + 32'(i));
        commit_now();
        n_cmp++;
        if (bus.cfg_data !== '0 || bus.cfg_update !== 1'b0) begin
            n_bad++;
            $display("FAIL imm_early upd=%b word0=%h exp upd=0 word0=0", bus.cfg_update, bus.cfg_data[31:0]);
        end
        tick();
        n_cmp++;
        if (bus.cfg_data !== pack_words(applied_m) || bus.cfg_update !== 1'b1 || bus.commit_count !== 16'd1) begin
            n_bad++;
            $display("FAIL imm_apply upd=%b cnt=%h w25=%h exp upd=1 cnt=1 w25=%h",
                     bus.cfg_update, bus.commit_count, bus.cfg_data[831:800], applied_m[25]);
        end
        tick();
        n_cmp++;
        if (bus.cfg_update !== 1'b0) begin
            n_bad++;
            $display("FAIL imm_strobe_len upd=%b exp 0", bus.cfg_update);
        end
    endtask

    task automatic test_armed_sync();
        logic [31:0] old_w2;
        old_w2 = applied_m[2];
        write_word(2, 32'hDEADBEEF);
        push_expected();
        bus.commit_req  = 1'b1;
        bus.commit_wait = 8'd3;
        bus.sync_pulse  = 1'b1;   // coincident pulse must not count
        tick();
        bus.commit_req  = 1'b0;
        bus.sync_pulse  = 1'b0;
        n_cmp++;
        if (bus.armed !== 1'b1 || bus.wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL armed_flags armed=%b rdy=%b exp armed=1 rdy=0", bus.armed, bus.wr_ready);
        end
        for (int p = 0; p < 3; p++) begin
            repeat (9) tick();
            n_cmp++;
            if (bus.cfg_data[95:64] !== old_w2 || bus.armed !== 1'b1) begin
                n_bad++;
                $display("FAIL armed_hold p=%0d w2=%h armed=%b exp w2=%h armed=1", p, bus.cfg_data[95:64], bus.armed, old_w2);
            end
            bus.sync_pulse = 1'b1;
            tick();
            bus.sync_pulse = 1'b0;
        end
        n_cmp++;
        if (bus.armed !== 1'b0 || bus.cfg_data[95:64] !== old_w2) begin
            n_bad++;
            $display("FAIL armed_apply_cycle armed=%b w2=%h exp armed=0 w2=%h", bus.armed, bus.cfg_data[95:64], old_w2);
        end
        tick();
        n_cmp++;
        if (bus.cfg_data[95:64] !== 32'hDEADBEEF || bus.cfg_update !== 1'b1) begin
            n_bad++;
            $display("FAIL armed_update w2=%h upd=%b exp w2=deadbeef upd=1", bus.cfg_data[95:64], bus.cfg_update);
        end
        tick();
    endtask

    task automatic test_armed_blocking();
        push_expected();
        bus.commit_req  = 1'b1;
        bus.commit_wait = 8'd1;
        tick();
        bus.commit_req  = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd5;
        bus.wr_data  = 32'hBAD0BAD0;
        tick();
        bus.wr_valid = 1'b0;
        n_cmp++;
        if (bus.wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL blk_wr_ready got %b exp 0", bus.wr_ready);
        end
        bus.commit_req  = 1'b1;
        bus.commit_wait = 8'd0;
        tick();
        bus.commit_req  = 1'b0;
        n_cmp++;
        if (bus.commit_err !== 1'b1 || bus.armed !== 1'b1) begin
            n_bad++;
            $display("FAIL blk_commit_err err=%b armed=%b exp err=1 armed=1", bus.commit_err, bus.armed);
        end
        bus.sync_pulse = 1'b1;
        tick();
        bus.sync_pulse = 1'b0;
        tick();
        n_cmp++;
        if (bus.cfg_data[191:160] !== applied_m[5] || bus.commit_count !== count_m) begin
            n_bad++;
            $display("FAIL blk_word5 w5=%h cnt=%h exp w5=%h cnt=%h",
                     bus.cfg_data[191:160], bus.commit_count, applied_m[5], count_m);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_cmp++;
        if (bus.commit_err !== 1'b0) begin
            n_bad++;
            $display("FAIL blk_err_clr got %b exp 0", bus.commit_err);
        end
    endtask

    task automatic test_abort();
        write_word(7, 32'h00000077);
        bus.commit_req  = 1'b1;
        bus.commit_wait = 8'd2;
        tick();
        bus.commit_req  = 1'b0;
        bus.sync_pulse  = 1'b1;
        tick();
        bus.abort = 1'b1;         // abort together with the final pulse
        tick();
        bus.sync_pulse = 1'b0;
        bus.abort      = 1'b0;
        n_cmp++;
        if (bus.armed !== 1'b0 || bus.wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_idle armed=%b rdy=%b exp armed=0 rdy=1", bus.armed, bus.wr_ready);
        end
        repeat (4) tick();
        n_cmp++;
        if (bus.cfg_data[255:224] !== applied_m[7] || bus.commit_count !== count_m) begin
            n_bad++;
            $display("FAIL abort_no_update w7=%h cnt=%h exp w7=%h cnt=%h",
                     bus.cfg_data[255:224], bus.commit_count, applied_m[7], count_m);
        end
        bus.commit_req  = 1'b1;
        bus.commit_wait = 8'd5;
        tick();
        bus.commit_req  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if (bus.cfg_data !== '0 || bus.armed !== 1'b0 || bus.cfg_update !== 1'b0 ||
            bus.commit_count !== 16'h0 || bus.wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_armed armed=%b upd=%b cnt=%h rdy=%b exp 0/0/0/1",
                     bus.armed, bus.cfg_update, bus.commit_count, bus.wr_ready);
        end
        repeat (6) tick();
    endtask

    task automatic test_addr_err();
        write_word(3, 32'h00000033);
        write_word(26, 32'hAAAAAAAA);
        n_cmp++;
        if (bus.addr_err !== 1'b1) begin
            n_bad++;
            $display("FAIL addr_err_26 got %b exp 1", bus.addr_err);
        end
        bus.err_clr = 1'b1;       // error event coincident with clear keeps flag set
        write_word(31, 32'h55555555);
        bus.err_clr = 1'b0;
        n_cmp++;
        if (bus.addr_err !== 1'b1) begin
            n_bad++;
            $display("FAIL addr_err_clr_race got %b exp 1", bus.addr_err);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_cmp++;
        if (bus.addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL addr_err_clear got %b exp 0", bus.addr_err);
        end
        commit_now();
        tick();
        n_cmp++;
        if (bus.cfg_data !== pack_words(applied_m)) begin
            n_bad++;
            $display("FAIL addr_err_cfg w3=%h w0=%h exp w3=00000033 w0=0", bus.cfg_data[127:96], bus.cfg_data[31:0]);
        end
        tick();
    endtask

    task automatic test_back_to_back_wrap();
        force dut.commit_count_q = 16'hFFFF;
        #1;
        release dut.commit_count_q;
        count_m = 16'hFFFF;
        n_cmp++;
        if (bus.commit_count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL wrap_preload got %h exp ffff", bus.commit_count);
        end
        write_word(0, 32'hCAFE0000);
        commit_now();
        tick();
        n_cmp++;
        if (bus.commit_count !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap_count got %h exp 0000", bus.commit_count);
        end
        write_word(1, 32'hCAFE0001);
        commit_now();
        tick();
        n_cmp++;
        if (bus.commit_count !== 16'h0001 || bus.cfg_data[63:32] !== 32'hCAFE0001) begin
            n_bad++;
            $display("FAIL b2b_count cnt=%h w1=%h exp cnt=0001 w1=cafe0001", bus.commit_count, bus.cfg_data[63:32]);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_immediate();
        test_armed_sync();
        test_armed_blocking();
        test_abort();
        test_addr_err();
        test_back_to_back_wrap();
        repeat (3) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain pending=%0d exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
